path_count_scheduler: RTL and testbench
=======================================

Name: path_count_scheduler

Overview:
- Consumes the topologically sorted node stream and counts distinct paths from start_node to end_node.
- Buffers the sorted order, then replays it. For each node it issues an adjacency-map query and adds that node's path count into every successor's count.
- Sits downstream of the sort stage. Owns the adjacency map query/reply port once sorting has finished.

Parameters:
- MAX_NODES, 1024, node capacity of the order buffer and the count RAM.
- NODE_WIDTH, $clog2(MAX_NODES), node index width.
- COUNT_WIDTH, 64, path counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start_node  in  NODE_WIDTH  path source; sampled when sorted_done is seen.
- end_node  in  NODE_WIDTH  path sink; sampled when sorted_done is seen.
- sorted_valid  in  1  one sorted node is present this cycle.
- sorted_node  in  NODE_WIDTH  sorted node index.
- sorted_done  in  1  sort finished; level signal.
- query_ready  in  1  adjacency map accepts a query.
- query_valid  out  1  query request.
- query_data  out  NODE_WIDTH  node whose successors are requested.
- reply_valid  in  1  reply beat present.
- reply_ready  out  1  reply beat consumed.
- reply_data  in  NODE_WIDTH  successor node.
- reply_last  in  1  final successor of the current query.
- reply_no_edges_found  in  1  node has no successors; reply_data is ignored.
- result_valid  out  1  result_count is final.
- result_count  out  COUNT_WIDTH  number of start-to-end paths.
- overflow  out  1  sorted stream exceeded MAX_NODES.

Behaviour:
- Reset values: all outputs 0; state IDLE; write and read pointers 0. Buffer and RAM contents are not reset.
- IDLE → COLLECT unconditionally.
- COLLECT:
  - Each sorted_valid writes sorted_node into the order buffer and increments the write pointer.
  - A write when the write pointer equals MAX_NODES is dropped and sets overflow (sticky until reset).
  - When sorted_done is seen, latch start_node, end_node and the node total, then go to CLEAR.
  - sorted_valid and sorted_done in the same cycle: the node is stored before the transition.
- CLEAR:
  - Write 0 to count RAM addresses 0..MAX_NODES-1, one per cycle.
  - In the final cycle, write count[start]=1, then go to LOAD.
- LOAD:
  - If read pointer equals node total, go to DONE with result = count[end].
  - Otherwise read buffer[rd_ptr] into cur_node, increment rd_ptr, and start a count RAM read of cur_node.
  - Both RAMs have 1-cycle synchronous read; go to CHECK.
- CHECK:
  - If cur_node == end_node, go to DONE. No later node in topological order can reach end.
  - Else if count[cur]==0, go to LOAD; the query is skipped.
  - Else hold cur_count and go to QUERY.
- QUERY:
  - query_valid=1 and query_data=cur_node, held stable until query_ready. Then go to WAIT_REPLY.
- WAIT_REPLY:
  - On reply_valid with reply_no_edges_found: assert reply_ready for 1 cycle, then go to LOAD.
  - On reply_valid otherwise: issue a count RAM read of reply_data, then go to ACCUM.
- ACCUM:
  - Write count[dst] = sat(count[dst] + cur_count) and assert reply_ready for 1 cycle.
  - The addition saturates at all-ones.
  - If reply_last, go to LOAD; else go to WAIT_REPLY.
  - Throughput is at most one successor per 2 cycles, so read/write ordering within an update is safe by construction.
- DONE:
  - result_valid=1 and result_count held until reset.
  - start_node == end_node gives result 1 via the first CHECK.
  - If start is never sorted, or end is unreachable, the result is 0.
  - An empty stream gives result 0: LOAD goes straight to DONE.
- Reset asserted mid-operation: the block returns to IDLE asynchronously and the adjacency handshake is abandoned. CLEAR guarantees stale RAM contents are harmless.
- query_valid is never dropped before acceptance, and reply_ready is only asserted while reply_valid is high.

Decomposition:
- Shared package holds: node_t, count_t, the state enum, and a COUNT_SAT constant.
- One sub-module, count_ram: single-port memory of MAX_NODES x COUNT_WIDTH with synchronous read and write. The order buffer is inferred inline.

Test Plan:
- Chain 0→1→2, sort order 0,1,2, start=0, end=2 → result_valid=1, result_count=1, exactly 2 queries (nodes 0 and 1).
- Diamond 0→{1,2}, 1→3, 2→3, start=0, end=3 → result_count=2; node 3 is never queried.
- Sort order 5,0,1, start=0, end=5 → node 5 is checked first and the block exits with result_count=0.
- start=end=4 → result_count=1 with no queries issued.
- 70-level layered graph with each level fanning 2→2, COUNT_WIDTH=64 → count saturates at 64'hFFFF_FFFF_FFFF_FFFF with no wrap.
- rst_n pulsed low during ACCUM; then rerun the diamond → outputs 0 during reset, final result_count=2. Also push 1025 sorted nodes with MAX_NODES=1024 → overflow=1.

Source files
------------

// File: rtl/path_count_scheduler_pkg.sv
// path_count_scheduler_pkg: shared types and constants for the path counting stage
package path_count_scheduler_pkg;
  localparam int DEF_MAX_NODES = 1024;
  localparam int DEF_NODE_WIDTH = $clog2(DEF_MAX_NODES);
  localparam int DEF_COUNT_WIDTH = 64;
  typedef logic [DEF_NODE_WIDTH-1:0] node_t;
  typedef logic [DEF_COUNT_WIDTH-1:0] count_t;
  localparam count_t COUNT_SAT = '1;
  typedef enum logic [3:0] {
    IDLE, COLLECT, CLEAR, LOAD, CHECK, QUERY, WAIT_REPLY, ACCUM, DONE
  } state_t;
endpackage

// File: rtl/path_count_scheduler_count_ram.sv
// path_count_scheduler_count_ram: single-port per-node path count memory, synchronous read and write
module path_count_scheduler_count_ram #(
  parameter int DEPTH = 1024,
  parameter int AW = 10,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/path_count_scheduler.sv
// path_count_scheduler: buffers the topological order, then replays it accumulating path counts into successors
module path_count_scheduler
  import path_count_scheduler_pkg::*;
#(
  parameter int MAX_NODES = DEF_MAX_NODES,
  parameter int NODE_WIDTH = $clog2(MAX_NODES),
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NODE_WIDTH-1:0]  start_node,
  input  logic [NODE_WIDTH-1:0]  end_node,
  input  logic                   sorted_valid,
  input  logic [NODE_WIDTH-1:0]  sorted_node,
  input  logic                   sorted_done,
  input  logic                   query_ready,
  output logic                   query_valid,
  output logic [NODE_WIDTH-1:0]  query_data,
  input  logic                   reply_valid,
  output logic                   reply_ready,
  input  logic [NODE_WIDTH-1:0]  reply_data,
  input  logic                   reply_last,
  input  logic                   reply_no_edges_found,
  output logic                   result_valid,
  output logic [COUNT_WIDTH-1:0] result_count,
  output logic                   overflow
);
  localparam int PW = NODE_WIDTH + 1;
  localparam logic [PW-1:0] FULL = PW'(MAX_NODES);
  state_t state, state_n;
  logic [PW-1:0] wr_ptr, rd_ptr, total, clr_ptr;
  logic [NODE_WIDTH-1:0] start_r, end_r, cur_node, dst, buf_q, addr;
  logic [COUNT_WIDTH-1:0] cur_count, rdata, wdata;
  logic [COUNT_WIDTH:0] wsum;
  logic we, wr_ok, at_end, clr_last;
  logic [NODE_WIDTH-1:0] order_buf [MAX_NODES];
  assign wr_ok = state == COLLECT && sorted_valid && wr_ptr != FULL;
  assign at_end = rd_ptr == total;
  assign clr_last = clr_ptr == FULL;
  assign wsum = {1'b0, rdata} + {1'b0, cur_count};
  assign query_data = cur_node;
  // buf_q continuously tracks order_buf[rd_ptr]; rd_ptr only moves in LOAD, so it is settled on every LOAD entry
  always_ff @(posedge clk) begin
    if (wr_ok) order_buf[wr_ptr[NODE_WIDTH-1:0]] <= sorted_node;
    buf_q <= order_buf[rd_ptr[NODE_WIDTH-1:0]];
  end
  path_count_scheduler_count_ram #(.DEPTH(MAX_NODES), .AW(NODE_WIDTH), .DW(COUNT_WIDTH)) count_ram (
    .clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );
  // the RAM address idles on end_r so count[end] is already on rdata when DONE is entered
  always_comb begin
    state_n = state;
    addr = end_r;
    we = 1'b0;
    wdata = '0;
    query_valid = 1'b0;
    reply_ready = 1'b0;
    case (state)
      IDLE: state_n = COLLECT;
      COLLECT: state_n = sorted_done ? CLEAR : COLLECT;
      CLEAR: begin
        we = 1'b1;
        addr = clr_last ? start_r : clr_ptr[NODE_WIDTH-1:0];
        wdata = clr_last ? COUNT_WIDTH'(1) : '0;
        state_n = clr_last ? LOAD : CLEAR;
      end
      LOAD: begin
        addr = at_end ? end_r : buf_q;
        state_n = at_end ? DONE : CHECK;
      end
      CHECK: state_n = cur_node == end_r ? DONE : rdata == '0 ? LOAD : QUERY;
      QUERY: begin
        query_valid = 1'b1;
        state_n = query_ready ? WAIT_REPLY : QUERY;
      end
      WAIT_REPLY: begin
        addr = reply_valid ? reply_data : end_r;
        reply_ready = reply_valid && reply_no_edges_found;
        state_n = !reply_valid ? WAIT_REPLY : reply_no_edges_found ? LOAD : ACCUM;
      end
      ACCUM: begin
        we = 1'b1;
        addr = dst;
        wdata = wsum[COUNT_WIDTH] ? COUNT_WIDTH'(COUNT_SAT) : wsum[COUNT_WIDTH-1:0];
        reply_ready = reply_valid;
        state_n = reply_last ? LOAD : WAIT_REPLY;
      end
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      total <= '0;
      clr_ptr <= '0;
      start_r <= '0;
      end_r <= '0;
      cur_node <= '0;
      cur_count <= '0;
      dst <= '0;
      overflow <= 1'b0;
      result_valid <= 1'b0;
      result_count <= '0;
    end else begin
      state <= state_n;
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (state == COLLECT && sorted_valid && !wr_ok) overflow <= 1'b1;
      if (state == COLLECT && sorted_done) begin
        start_r <= start_node;
        end_r <= end_node;
        total <= wr_ptr + PW'(wr_ok);
      end
      if (state == CLEAR) clr_ptr <= clr_ptr + PW'(1);
      if (state == LOAD && !at_end) begin
        cur_node <= buf_q;
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (state == CHECK) cur_count <= rdata;
      if (state == WAIT_REPLY) dst <= reply_data;
      if (state == DONE && !result_valid) begin
        result_valid <= 1'b1;
        result_count <= rdata;
      end
    end
  end
endmodule

// File: tb/tb_path_count_scheduler.sv
// tb_path_count_scheduler: directed and random DAGs checked against a backward paths-to-end reference model
module tb_path_count_scheduler;
  localparam int NW = 10;
  localparam logic [63:0] SATV = 64'hFFFF_FFFF_FFFF_FFFF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NW-1:0] start_node, end_node, sorted_node, query_data, reply_data;
  logic sorted_valid, sorted_done, query_ready, query_valid, reply_valid, reply_ready;
  logic reply_last, reply_no_edges_found, result_valid, overflow;
  logic [63:0] result_count;
  int checks = 0;
  int failures = 0;
  int adj [1024][$];
  int qlog[$];
  int rq[$];
  bit active, done_beat;

  always #5 clk = ~clk;

  path_count_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start_node(start_node), .end_node(end_node),
    .sorted_valid(sorted_valid), .sorted_node(sorted_node), .sorted_done(sorted_done),
    .query_ready(query_ready), .query_valid(query_valid), .query_data(query_data),
    .reply_valid(reply_valid), .reply_ready(reply_ready), .reply_data(reply_data),
    .reply_last(reply_last), .reply_no_edges_found(reply_no_edges_found),
    .result_valid(result_valid), .result_count(result_count), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // adjacency map model: accepts queries, streams successor beats with random gaps
  initial begin
    query_ready = 1'b0;
    reply_valid = 1'b0;
    reply_data = '0;
    reply_last = 1'b0;
    reply_no_edges_found = 1'b0;
    active = 1'b0;
    done_beat = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        query_ready = 1'b0;
        reply_valid = 1'b0;
        active = 1'b0;
        done_beat = 1'b0;
        rq.delete();
        continue;
      end
      if (done_beat) begin
        reply_valid = 1'b0;
        done_beat = 1'b0;
      end
      query_ready = !active && ($urandom_range(0, 3) != 0);
      if (!reply_valid && active && $urandom_range(0, 3) != 0) begin
        reply_valid = 1'b1;
        reply_no_edges_found = rq.size() == 0;
        reply_data = rq.size() != 0 ? NW'(rq[0]) : NW'($urandom);
        reply_last = rq.size() <= 1;
      end
      #1;
      if (reply_ready) chk("ready_without_valid", 64'(reply_valid), 64'd1);
      if (query_valid && query_ready) begin
        qlog.push_back(int'(query_data));
        rq = adj[query_data];
        active = 1'b1;
      end
      if (reply_valid && reply_ready) begin
        done_beat = 1'b1;
        if (rq.size() != 0) void'(rq.pop_front());
        if (reply_last) active = 1'b0;
      end
    end
  end

  function automatic void model(input int ord[$], input int s, input int e,
                                output logic [63:0] cnt, output int nq);
    logic [63:0] ways [1024];
    bit reach [1024];
    bit in_ord [1024];
    for (int i = 0; i < 1024; i++) begin
      ways[i] = '0;
      reach[i] = 1'b0;
      in_ord[i] = 1'b0;
    end
    foreach (ord[i]) in_ord[ord[i]] = 1'b1;
    // number of paths from each node to e, walking the order backwards
    for (int i = ord.size() - 1; i >= 0; i--) begin
      int n;
      n = ord[i];
      ways[n] = (n == e) ? 64'd1 : 64'd0;
      if (n != e)
        for (int k = 0; k < adj[n].size(); k++) begin
          logic [63:0] w;
          w = ways[adj[n][k]];
          ways[n] = (ways[n] > SATV - w) ? SATV : ways[n] + w;
        end
    end
    cnt = in_ord[s] ? ways[s] : 64'd0;
    reach[s] = in_ord[s];
    repeat (ord.size())
      foreach (ord[i])
        if (reach[ord[i]])
          for (int k = 0; k < adj[ord[i]].size(); k++) reach[adj[ord[i]][k]] = 1'b1;
    nq = 0;
    foreach (ord[i]) begin
      if (ord[i] == e) break;
      if (reach[ord[i]]) nq++;
    end
  endfunction

  task automatic clear_graph();
    for (int i = 0; i < 1024; i++) adj[i].delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sorted_valid = 1'b0;
    sorted_done = 1'b0;
    repeat (3) @(negedge clk);
    qlog.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic feed(input int ord[$], input int s, input int e);
    bit same;
    same = 1'($urandom_range(0, 1));
    start_node = NW'(s);
    end_node = NW'(e);
    foreach (ord[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        sorted_valid = 1'b0;
        @(negedge clk);
      end
      sorted_valid = 1'b1;
      sorted_node = NW'(ord[i]);
      sorted_done = same && i == ord.size() - 1;
      @(negedge clk);
    end
    sorted_valid = 1'b0;
    sorted_done = 1'b1;
  endtask

  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_case(input string tag, input int ord[$], input int s, input int e,
                          input bit use_model, input logic [63:0] exp);
    logic [63:0] mc;
    int mq;
    bit ok;
    model(ord, s, e, mc, mq);
    do_reset();
    feed(ord, s, e);
    wait_result(ok);
    chk({tag, " done"}, 64'(ok), 64'd1);
    chk({tag, " count"}, result_count, use_model ? mc : exp);
    chk({tag, " queries"}, 64'(qlog.size()), 64'(mq));
    chk({tag, " overflow"}, 64'(overflow), 64'd0);
    repeat (3) @(negedge clk);
    chk({tag, " held"}, 64'(result_valid), 64'd1);
  endtask

  task automatic build_layers(input int levels, output int ord[$]);
    clear_graph();
    ord.delete();
    ord.push_back(0);
    for (int l = 1; l <= levels; l++) begin
      ord.push_back(2 * l - 1);
      ord.push_back(2 * l);
    end
    ord.push_back(2 * levels + 1);
    adj[0].push_back(1);
    adj[0].push_back(2);
    for (int l = 1; l <= levels; l++)
      for (int a = 2 * l - 1; a <= 2 * l; a++)
        if (l == levels) adj[a].push_back(2 * levels + 1);
        else begin
          adj[a].push_back(2 * l + 1);
          adj[a].push_back(2 * l + 2);
        end
  endtask

  task automatic build_diamond(output int ord[$]);
    clear_graph();
    adj[0] = '{1, 2};
    adj[1] = '{3};
    adj[2] = '{3};
    ord = '{0, 1, 2, 3};
  endtask

  initial begin
    int ord[$];
    bit hit, saw3;
    start_node = '0;
    end_node = '0;
    sorted_node = '0;
    sorted_valid = 1'b0;
    sorted_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst result_valid", 64'(result_valid), 64'd0);
    chk("rst result_count", result_count, 64'd0);
    chk("rst query_valid", 64'(query_valid), 64'd0);
    chk("rst reply_ready", 64'(reply_ready), 64'd0);
    chk("rst overflow", 64'(overflow), 64'd0);

    clear_graph();
    adj[0] = '{1};
    adj[1] = '{2};
    run_case("chain", '{0, 1, 2}, 0, 2, 1'b0, 64'd1);
    chk("chain order", 64'(qlog.size() == 2 && qlog[0] == 0 && qlog[1] == 1), 64'd1);

    build_diamond(ord);
    run_case("diamond", ord, 0, 3, 1'b0, 64'd2);
    saw3 = 1'b0;
    foreach (qlog[i]) if (qlog[i] == 3) saw3 = 1'b1;
    chk("diamond no q3", 64'(saw3), 64'd0);

    clear_graph();
    adj[0] = '{1};
    run_case("end_first", '{5, 0, 1}, 0, 5, 1'b0, 64'd0);

    clear_graph();
    adj[2] = '{4};
    adj[4] = '{7};
    run_case("start_eq_end", '{2, 4, 7}, 4, 4, 1'b0, 64'd1);

    clear_graph();
    ord.delete();
    run_case("empty", ord, 3, 4, 1'b0, 64'd0);

    build_layers(63, ord);
    run_case("layers63", ord, 0, 127, 1'b0, 64'h8000_0000_0000_0000);
    build_layers(70, ord);
    run_case("layers70_sat", ord, 0, 141, 1'b0, SATV);

    build_diamond(ord);
    do_reset();
    feed(ord, 0, 3);
    hit = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      #2;
      if (reply_valid && reply_ready && !reply_no_edges_found) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach accum", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst result_valid", 64'(result_valid), 64'd0);
    chk("midrst result_count", result_count, 64'd0);
    chk("midrst query_valid", 64'(query_valid), 64'd0);
    chk("midrst reply_ready", 64'(reply_ready), 64'd0);
    chk("midrst overflow", 64'(overflow), 64'd0);
    run_case("diamond_rerun", ord, 0, 3, 1'b0, 64'd2);

    clear_graph();
    do_reset();
    start_node = NW'(1);
    end_node = NW'(2);
    for (int i = 0; i < 1024; i++) begin
      sorted_valid = 1'b1;
      sorted_node = NW'(i);
      @(negedge clk);
    end
    chk("ovf at capacity", 64'(overflow), 64'd0);
    sorted_node = NW'(5);
    @(negedge clk);
    sorted_valid = 1'b0;
    @(negedge clk);
    chk("ovf past capacity", 64'(overflow), 64'd1);
    sorted_done = 1'b1;
    wait_result(hit);
    chk("ovf done", 64'(hit), 64'd1);
    chk("ovf count", result_count, 64'd0);
    chk("ovf queries", 64'(qlog.size()), 64'd1);
    chk("ovf sticky", 64'(overflow), 64'd1);

    for (int r = 0; r < 6; r++) begin
      int n, s, e;
      n = int'($urandom_range(3, 12));
      clear_graph();
      ord.delete();
      for (int i = 0; i < n; i++) ord.push_back(i * 37 + r * 3 + 1);
      for (int i = n - 1; i > 0; i--) begin
        int j, t;
        j = int'($urandom_range(0, i));
        t = ord[i];
        ord[i] = ord[j];
        ord[j] = t;
      end
      for (int i = 0; i < n; i++)
        for (int j = i + 1; j < n; j++)
          if ($urandom_range(0, 2) == 0) adj[ord[i]].push_back(ord[j]);
      s = ord[$urandom_range(0, n / 2)];
      e = ord[$urandom_range(n / 2, n - 1)];
      run_case($sformatf("rand%0d", r), ord, s, e, 1'b1, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
